// File: rtl/pad_serial_reader.sv
// rtl/pad_serial_reader.sv - NES-style serial game pad poller with two-frame agreement filter
//
// Polls a parallel-load, active-low serial controller every frame, deserialises
// the 8 button bits and publishes them only when two consecutive frames agree.
//
// Ports:
//   Clk         in   system clock
//   Reset       in   synchronous, active-high reset
//   pad_data    in   serial data from controller, 0 = pressed
//   pad_latch   out  parallel-load strobe to controller
//   pad_clk     out  shift clock to controller
//   buttons     out  filtered buttons, 1 = pressed:
//                    [0]A [1]B [2]Select [3]Start [4]Up [5]Down [6]Left [7]Right
//   dpad_dir    out  00 up, 01 right, 10 down, 11 left (priority Up>Right>Down>Left)
//   dpad_active out  any D-pad bit set in buttons
//   fire_btn    out  buttons[0] (A)
//   new_sample  out  one-cycle pulse when the filtered outputs are updated

module pad_serial_reader #(
    parameter int CLK_DIV     = 4,
    parameter int POLL_PERIOD = 16
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       pad_data,
    output logic       pad_latch,
    output logic       pad_clk,
    output logic [7:0] buttons,
    output logic [1:0] dpad_dir,
    output logic       dpad_active,
    output logic       fire_btn,
    output logic       new_sample
);

    // One counter serves every state; size it for the longest state.
    localparam int CNT_MAX = ((POLL_PERIOD > 2 * CLK_DIV) ? POLL_PERIOD : 2 * CLK_DIV) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(POLL_PERIOD - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = CNT_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_SAMPLE,
        S_PULSE,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       frame_q, frame_d;
    logic [7:0]       prev_frame_q;

    logic             pad_latch_q;
    logic             pad_clk_q;
    logic             done_q;
    logic [7:0]       buttons_q;
    logic [1:0]       dpad_dir_q;
    logic             dpad_active_q;
    logic             fire_btn_q;
    logic             new_sample_q;

    logic [1:0]       dir_d;
    logic             active_d;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            frame_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;

        unique case (state_q)
            S_IDLE: begin
                if (cnt_q == IDLE_LAST) begin
                    state_d = S_LATCH;
                    cnt_d   = '0;
                end
            end
            S_LATCH: begin
                if (cnt_q == LATCH_LAST) begin
                    state_d   = S_SAMPLE;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                end
            end
            S_SAMPLE: begin
                if (cnt_q == TICK_LAST) begin
                    // Sampled one cycle before pad_clk rises, so the controller's
                    // shift never races the capture.
                    frame_d[bit_idx_q] = ~pad_data;
                    cnt_d              = '0;
                    state_d            = (bit_idx_q == 3'd7) ? S_DONE : S_PULSE;
                end
            end
            S_PULSE: begin
                if (cnt_q == TICK_LAST) begin
                    state_d   = S_SAMPLE;
                    cnt_d     = '0;
                    bit_idx_d = (bit_idx_q == 3'd7) ? 3'd7 : bit_idx_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Direction encode, Up > Right > Down > Left
    // ------------------------------------------------------------------
    always_comb begin
        dir_d    = 2'b00;
        active_d = |frame_q[7:4];
        if (frame_q[4]) begin
            dir_d = 2'b00;
        end else if (frame_q[7]) begin
            dir_d = 2'b01;
        end else if (frame_q[5]) begin
            dir_d = 2'b10;
        end else if (frame_q[6]) begin
            dir_d = 2'b11;
        end
    end

    // ------------------------------------------------------------------
    // Output registers. Strobes are re-registered from the state so they
    // come straight off flops; the filter runs one cycle after DONE to keep
    // the published data aligned with the strobe timeline.
    // ------------------------------------------------------------------
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pad_latch_q   <= 1'b0;
            pad_clk_q     <= 1'b0;
            done_q        <= 1'b0;
            prev_frame_q  <= '0;
            buttons_q     <= '0;
            dpad_dir_q    <= '0;
            dpad_active_q <= 1'b0;
            fire_btn_q    <= 1'b0;
            new_sample_q  <= 1'b0;
        end else begin
            pad_latch_q  <= (state_q == S_LATCH);
            pad_clk_q    <= (state_q == S_PULSE);
            done_q       <= (state_q == S_DONE);
            new_sample_q <= 1'b0;
            if (done_q) begin
                prev_frame_q <= frame_q;
                if (frame_q == prev_frame_q) begin
                    buttons_q     <= frame_q;
                    dpad_dir_q    <= dir_d;
                    dpad_active_q <= active_d;
                    fire_btn_q    <= frame_q[0];
                    new_sample_q  <= 1'b1;
                end
            end
        end
    end

    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;
    assign buttons     = buttons_q;
    assign dpad_dir    = dpad_dir_q;
    assign dpad_active = dpad_active_q;
    assign fire_btn    = fire_btn_q;
    assign new_sample  = new_sample_q;

endmodule

// File: tb/tb_pad_serial_reader.sv
// tb/tb_pad_serial_reader.sv - directed self-checking bench for pad_serial_reader

module tb_pad_serial_reader;

    logic       Clk = 1'b0;
    logic       Reset = 1'b1;

    logic       pad_data, pad_latch, pad_clk;
    logic [7:0] buttons;
    logic [1:0] dpad_dir;
    logic       dpad_active, fire_btn, new_sample;

    logic       f_pad_data, f_pad_latch, f_pad_clk;
    logic [7:0] f_buttons;
    logic [1:0] f_dpad_dir;
    logic       f_dpad_active, f_fire_btn, f_new_sample;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 Clk = ~Clk;

    pad_serial_reader #(.CLK_DIV(4), .POLL_PERIOD(16)) u_dut (
        .Clk(Clk), .Reset(Reset), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .buttons(buttons),
        .dpad_dir(dpad_dir), .dpad_active(dpad_active), .fire_btn(fire_btn),
        .new_sample(new_sample)
    );

    pad_serial_reader #(.CLK_DIV(1), .POLL_PERIOD(1)) u_fast (
        .Clk(Clk), .Reset(Reset), .pad_data(f_pad_data),
        .pad_latch(f_pad_latch), .pad_clk(f_pad_clk), .buttons(f_buttons),
        .dpad_dir(f_dpad_dir), .dpad_active(f_dpad_active), .fire_btn(f_fire_btn),
        .new_sample(f_new_sample)
    );

    // Controller models: 4021-style shift register, loads on latch, shifts on clk.
    logic [7:0] pat = 8'h00;
    logic [7:0] sh = 8'hFF;
    assign pad_data = sh[0];
    always @(posedge pad_latch or posedge pad_clk) begin
        if (pad_latch) sh = ~pat;
        else           sh = {1'b1, sh[7:1]};
    end

    logic [7:0] f_pat = 8'hFF;
    logic [7:0] f_sh = 8'hFF;
    assign f_pad_data = f_sh[0];
    always @(posedge f_pad_latch or posedge f_pad_clk) begin
        if (f_pad_latch) f_sh = ~f_pat;
        else             f_sh = {1'b1, f_sh[7:1]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one frame with pattern p: waits for the latch rise, then watches
    // the 84 following cycles, which contain this frame's new_sample slot.
    task automatic do_frame(input logic [7:0] p, output int ns_n);
        logic prev;
        logic seen;
        int   w;
        pat  = p;
        prev = pad_latch;
        seen = 1'b0;
        w    = 0;
        ns_n = 0;
        while (!seen && w < 300) begin
            @(negedge Clk);
            w++;
            if (pad_latch && !prev) seen = 1'b1;
            prev = pad_latch;
        end
        if (!seen) check("latch_timeout", 32'd0, 32'd1);
        repeat (84) begin
            @(negedge Clk);
            if (new_sample) ns_n++;
        end
    endtask

    logic [7:0] tbl_pat [7] = '{8'h50, 8'h80, 8'h60, 8'hE0, 8'h40, 8'h30, 8'hC0};
    logic [1:0] tbl_dir [7] = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b11, 2'b00, 2'b01};

    initial begin
        int lat_first, lat_cnt, clk_first, clk_second, clk_hi, clk_rises, ns_first;
        int ns_n, rises, f_r1, f_r2, f_ns;
        logic prev_clk, prev_lat, done;
        logic [7:0] ns_btn, f_btn;
        logic [1:0] f_dir;
        logic ns_act, f_fire, f_act;

        // ---- Test 1: reset values and default-parameter frame timing ----
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst_latch", 32'(pad_latch), 32'd0);
        check("rst_clk", 32'(pad_clk), 32'd0);
        check("rst_buttons", 32'(buttons), 32'd0);
        check("rst_misc", 32'({dpad_dir, dpad_active, fire_btn, new_sample}), 32'd0);
        Reset = 1'b0;

        lat_first = -1; lat_cnt = 0; clk_first = -1; clk_second = -1;
        clk_hi = 0; clk_rises = 0; ns_first = -1; prev_clk = 1'b0;
        ns_btn = 8'hxx; ns_act = 1'bx;
        for (int k = 0; k <= 86; k++) begin
            @(negedge Clk);
            if (pad_latch) begin
                lat_cnt++;
                if (lat_first < 0) lat_first = k;
            end
            if (pad_clk) clk_hi++;
            if (pad_clk && !prev_clk) begin
                clk_rises++;
                if (clk_first < 0) clk_first = k;
                else if (clk_second < 0) clk_second = k;
            end
            prev_clk = pad_clk;
            if (new_sample && ns_first < 0) begin
                ns_first = k;
                ns_btn   = buttons;
                ns_act   = dpad_active;
            end
        end
        check("t1_latch_first", 32'(lat_first), 32'd16);
        check("t1_latch_len", 32'(lat_cnt), 32'd8);
        check("t1_clk_first", 32'(clk_first), 32'd28);
        check("t1_clk_second", 32'(clk_second), 32'd36);
        check("t1_clk_hi_cycles", 32'(clk_hi), 32'd28);
        check("t1_clk_pulses", 32'(clk_rises), 32'd7);
        check("t1_ns_cycle", 32'(ns_first), 32'd85);
        check("t1_ns_buttons", 32'(ns_btn), 32'h00);
        check("t1_ns_active", 32'(ns_act), 32'd0);

        // ---- Test 2: A pressed from reset, needs two agreeing frames ----
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        do_frame(8'h01, ns_n);
        check("t2_f1_ns", 32'(ns_n), 32'd0);
        check("t2_f1_buttons", 32'(buttons), 32'h00);
        do_frame(8'h01, ns_n);
        check("t2_f2_ns", 32'(ns_n), 32'd1);
        check("t2_f2_buttons", 32'(buttons), 32'h01);
        check("t2_f2_fire", 32'(fire_btn), 32'd1);
        check("t2_f2_active", 32'(dpad_active), 32'd0);

        // ---- Test 4: single-frame glitch is rejected ----
        do_frame(8'h00, ns_n);
        check("t4_release_ns", 32'(ns_n), 32'd0);
        check("t4_release_hold", 32'(buttons), 32'h01);
        do_frame(8'h00, ns_n);
        check("t4_idle_ns", 32'(ns_n), 32'd1);
        check("t4_idle_buttons", 32'(buttons), 32'h00);
        check("t4_idle_fire", 32'(fire_btn), 32'd0);
        do_frame(8'h00, ns_n);
        check("t4_unchanged_ns", 32'(ns_n), 32'd1);
        do_frame(8'h08, ns_n);
        check("t4_glitch_ns", 32'(ns_n), 32'd0);
        check("t4_glitch_buttons", 32'(buttons), 32'h00);
        do_frame(8'h00, ns_n);
        check("t4_after_ns", 32'(ns_n), 32'd0);
        check("t4_after_buttons", 32'(buttons), 32'h00);
        do_frame(8'h00, ns_n);
        check("t4_settle_ns", 32'(ns_n), 32'd1);

        // ---- Test 3: direction priority table ----
        for (int i = 0; i < 7; i++) begin
            do_frame(tbl_pat[i], ns_n);
            check($sformatf("t3_first_ns_%02h", tbl_pat[i]), 32'(ns_n), 32'd0);
            do_frame(tbl_pat[i], ns_n);
            check($sformatf("t3_ns_%02h", tbl_pat[i]), 32'(ns_n), 32'd1);
            check($sformatf("t3_buttons_%02h", tbl_pat[i]), 32'(buttons), 32'(tbl_pat[i]));
            check($sformatf("t3_dir_%02h", tbl_pat[i]), 32'(dpad_dir), 32'(tbl_dir[i]));
            check($sformatf("t3_active_%02h", tbl_pat[i]), 32'(dpad_active), 32'd1);
            check($sformatf("t3_fire_%02h", tbl_pat[i]), 32'(fire_btn), 32'd0);
        end

        // ---- Test 5: reset during the 3rd pad_clk pulse ----
        prev_lat = pad_latch; done = 1'b0;
        for (int w = 0; w < 300 && !done; w++) begin
            @(negedge Clk);
            if (pad_latch && !prev_lat) done = 1'b1;
            prev_lat = pad_latch;
        end
        check("t5_latch_seen", 32'(done), 32'd1);
        rises = 0; prev_clk = pad_clk;
        for (int w = 0; w < 100 && rises < 3; w++) begin
            @(negedge Clk);
            if (pad_clk && !prev_clk) rises++;
            prev_clk = pad_clk;
        end
        check("t5_third_pulse", 32'(rises), 32'd3);
        Reset = 1'b1;
        @(negedge Clk);
        check("t5_clk_low", 32'(pad_clk), 32'd0);
        check("t5_latch_low", 32'(pad_latch), 32'd0);
        check("t5_buttons_clr", 32'(buttons), 32'h00);
        check("t5_dir_clr", 32'({dpad_dir, dpad_active}), 32'd0);
        Reset = 1'b0;
        lat_first = -1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge Clk);
            if (pad_latch && lat_first < 0) lat_first = k;
        end
        check("t5_latch_after_rst", 32'(lat_first), 32'd16);

        // ---- Test 6: CLK_DIV=1, POLL_PERIOD=1, all buttons pressed ----
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        f_r1 = -1; f_r2 = -1; f_ns = -1; prev_lat = 1'b0;
        f_btn = 8'hxx; f_dir = 2'bxx; f_fire = 1'bx; f_act = 1'bx;
        for (int k = 0; k <= 45; k++) begin
            @(negedge Clk);
            if (f_pad_latch && !prev_lat) begin
                if (f_r1 < 0) f_r1 = k;
                else if (f_r2 < 0) f_r2 = k;
            end
            prev_lat = f_pad_latch;
            if (f_new_sample && f_ns < 0) begin
                f_ns   = k;
                f_btn  = f_buttons;
                f_dir  = f_dpad_dir;
                f_fire = f_fire_btn;
                f_act  = f_dpad_active;
            end
        end
        check("t6_latch_first", 32'(f_r1), 32'd1);
        check("t6_frame_len", 32'(f_r2 - f_r1), 32'd19);
        check("t6_ns_cycle", 32'(f_ns), 32'd38);
        check("t6_buttons", 32'(f_btn), 32'hFF);
        check("t6_dir", 32'(f_dir), 32'd0);
        check("t6_fire", 32'(f_fire), 32'd1);
        check("t6_active", 32'(f_act), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
